// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter between four channel FIFOs and one output FIFO.
// Each cycle it pops one word from a non-empty channel. One cycle later it
// captures that word and writes it, registered, into the output FIFO.
module fifo_rr_arbiter #(
   parameter int DATA_SIZE = 6,
   parameter int CNT_SIZE  = 8
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic [3:0]           fifo_empty,
   input  logic [DATA_SIZE-1:0] data_in0,
   input  logic [DATA_SIZE-1:0] data_in1,
   input  logic [DATA_SIZE-1:0] data_in2,
   input  logic [DATA_SIZE-1:0] data_in3,
   input  logic                 down_pause,
   input  logic                 down_full,
   output logic [3:0]           pop,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 push_out,
   output logic [1:0]           grant_ch,
   output logic [CNT_SIZE-1:0]  word_count
);

   logic [1:0]           r_last_grant;
   logic [1:0]           r_sel_q;
   logic                 r_pv;
   logic [DATA_SIZE-1:0] r_data_out;
   logic                 r_push_out;
   logic [1:0]           r_grant_ch;
   logic [CNT_SIZE-1:0]  r_word_count;

   logic                 w_go;
   logic [1:0]           w_sel;
   logic [1:0]           w_idx;
   logic                 w_found;
   logic [DATA_SIZE-1:0] w_data_sel;

   // A new pop is only issued when the output FIFO has room and some channel has data.
   assign w_go = !down_pause && !down_full && (fifo_empty != 4'b1111);

   // Search order starts just after the last grant; last_grant itself is checked last.
   always_comb begin
      w_sel   = r_last_grant;
      w_idx   = r_last_grant;
      w_found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         w_idx = r_last_grant + 2'(i);
         if (!w_found && !fifo_empty[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   // One-hot pop strobe; held low during reset so nothing is read from the channels.
   always_comb begin
      pop = 4'b0000;
      if (reset_L && w_go) begin
         pop[w_sel] = 1'b1;
      end
   end

   // The channel FIFO presents its word the cycle after the pop, selected by sel_q.
   always_comb begin
      w_data_sel = data_in0;
      case (r_sel_q)
         2'd0:    w_data_sel = data_in0;
         2'd1:    w_data_sel = data_in1;
         2'd2:    w_data_sel = data_in2;
         default: w_data_sel = data_in3;
      endcase
   end

   // Pop stage: remember who was granted and mark the word as in flight.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_last_grant <= 2'd3;
         r_sel_q      <= 2'd0;
         r_pv         <= 1'b0;
      end else begin
         r_pv <= w_go;
         if (w_go) begin
            r_last_grant <= w_sel;
            r_sel_q      <= w_sel;
         end
      end
   end

   // Push stage: capture the popped word and write it to the output FIFO.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_data_out   <= '0;
         r_push_out   <= 1'b0;
         r_grant_ch   <= 2'd0;
         r_word_count <= '0;
      end else begin
         r_push_out <= r_pv;
         if (r_pv) begin
            r_data_out   <= w_data_sel;
            r_grant_ch   <= r_sel_q;
            r_word_count <= r_word_count + CNT_SIZE'(1);
         end
      end
   end

   assign data_out   = r_data_out;
   assign push_out   = r_push_out;
   assign grant_ch   = r_grant_ch;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: behavioural channel FIFOs, a queue-based
// round-robin reference model and a scoreboard checked by a separate monitor.
module tb_fifo_rr_arbiter;

   localparam int DW = 6;
   localparam int CW = 8;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    ch;
      logic [CW-1:0] cnt;
      int            due;
   } item_t;

   logic          clk;
   logic          reset_L;
   logic [3:0]    fifo_empty;
   logic [DW-1:0] din [4];
   logic          down_pause;
   logic          down_full;
   logic [3:0]    pop;
   logic [DW-1:0] data_out;
   logic          push_out;
   logic [1:0]    grant_ch;
   logic [CW-1:0] word_count;

   logic [DW-1:0] chq [4][$];
   item_t         sb [$];
   int            n_checks;
   int            n_errors;
   int            cyc;
   int            m_last;
   int            m_cnt;
   int            m_pop_ch;

   fifo_rr_arbiter #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
      .clk        (clk),
      .reset_L    (reset_L),
      .fifo_empty (fifo_empty),
      .data_in0   (din[0]),
      .data_in1   (din[1]),
      .data_in2   (din[2]),
      .data_in3   (din[3]),
      .down_pause (down_pause),
      .down_full  (down_full),
      .pop        (pop),
      .data_out   (data_out),
      .push_out   (push_out),
      .grant_ch   (grant_ch),
      .word_count (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic refresh();
      for (int k = 0; k < 4; k++) fifo_empty[k] = (chq[k].size() == 0);
   endtask

   // Advance one cycle; the channel FIFO model applies the pop the model predicted.
   task automatic step();
      @(posedge clk);
      #1;
      if (m_pop_ch >= 0 && chq[m_pop_ch].size() > 0) din[m_pop_ch] = chq[m_pop_ch].pop_front();
      m_pop_ch = -1;
      refresh();
   endtask

   task automatic load(int ch, int val);
      chq[ch].push_back(DW'(val));
      refresh();
   endtask

   task automatic enter_reset();
      reset_L    = 1'b0;
      sb.delete();
      m_pop_ch   = -1;
      down_pause = 1'b0;
      down_full  = 1'b0;
      for (int k = 0; k < 4; k++) chq[k].delete();
      refresh();
   endtask

   task automatic drain(int budget);
      int done;
      done = 0;
      for (int i = 0; i < budget && done == 0; i++) begin
         step();
         done = (sb.size() == 0 && fifo_empty == 4'b1111) ? 1 : 0;
      end
      chk("drain_within_budget", done, 1);
   endtask

   // Reference model: round robin over the channel queues, evaluated once per cycle.
   always begin
      logic [3:0] exp_pop;
      item_t      it;
      @(negedge clk);
      #1;
      exp_pop  = 4'b0000;
      m_pop_ch = -1;
      if (!reset_L) begin
         m_last = 3;
         m_cnt  = 0;
         sb.delete();
      end else if (!down_pause && !down_full) begin
         for (int i = 1; i <= 4; i++) begin
            if (m_pop_ch < 0 && chq[(m_last + i) % 4].size() > 0) m_pop_ch = (m_last + i) % 4;
         end
      end
      if (m_pop_ch >= 0) begin
         exp_pop[m_pop_ch] = 1'b1;
         m_last  = m_pop_ch;
         m_cnt   = (m_cnt + 1) % (1 << CW);
         it.data = chq[m_pop_ch][0];
         it.ch   = 2'(m_pop_ch);
         it.cnt  = CW'(m_cnt);
         it.due  = cyc + 2;
         sb.push_back(it);
      end
      chk("pop", int'(pop), int'(exp_pop));
   end

   // Monitor: every push_out must match the oldest outstanding expected word.
   always begin
      item_t it;
      @(negedge clk);
      if (push_out) begin
         if (sb.size() == 0) begin
            chk("unexpected_push", 1, 0);
         end else begin
            it = sb.pop_front();
            chk("data_out", int'(data_out), int'(it.data));
            chk("grant_ch", int'(grant_ch), int'(it.ch));
            chk("word_count", int'(word_count), int'(it.cnt));
            chk("push_latency_cycle", cyc, it.due);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         it = sb.pop_front();
         chk("missing_push", 0, 1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_last   = 3;
      m_cnt    = 0;
      m_pop_ch = -1;
      for (int k = 0; k < 4; k++) din[k] = '0;
      enter_reset();
      step();
      step();
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_push_out", int'(push_out), 0);
      chk("rst_grant_ch", int'(grant_ch), 0);
      chk("rst_word_count", int'(word_count), 0);
      chk("rst_pop", int'(pop), 0);

      // Only channel 2 has data.
      load(2, 'h15);
      load(2, 'h2A);
      reset_L = 1'b1;
      drain(10);
      chk("ch2_word_count", int'(word_count), 2);
      chk("ch2_grant_ch", int'(grant_ch), 2);
      chk("ch2_data_last", int'(data_out), 'h2A);

      // All four channels, three words each.
      enter_reset();
      step();
      for (int k = 0; k < 4; k++) for (int j = 0; j < 3; j++) load(k, 'h10 + k);
      reset_L = 1'b1;
      drain(20);
      chk("all4_word_count", int'(word_count), 12);

      // Channels 0 and 3 only.
      enter_reset();
      step();
      load(0, 'h01); load(0, 'h02); load(3, 'h31); load(3, 'h32);
      reset_L = 1'b1;
      drain(12);
      chk("ch03_word_count", int'(word_count), 4);

      // Pause for four cycles mid-stream.
      enter_reset();
      step();
      for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) load(k, 8 * k + j);
      reset_L = 1'b1;
      repeat (3) step();
      down_pause = 1'b1;
      repeat (4) step();
      down_pause = 1'b0;
      drain(30);
      chk("pause_word_count", int'(word_count), 16);

      // Output FIFO full with every channel holding data.
      enter_reset();
      step();
      for (int k = 0; k < 4; k++) for (int j = 0; j < 3; j++) load(k, 'h20 + 4 * k + j);
      reset_L = 1'b1;
      repeat (2) step();
      down_full = 1'b1;
      repeat (6) step();
      chk("full_push_out", int'(push_out), 0);
      chk("full_word_count_frozen", int'(word_count), m_cnt);
      down_full = 1'b0;
      drain(30);

      // Reset pulse while a word is in flight.
      enter_reset();
      step();
      for (int k = 0; k < 4; k++) for (int j = 0; j < 3; j++) load(k, 'h30 + k);
      reset_L = 1'b1;
      repeat (4) step();
      chk("pre_rst_push_out", int'(push_out), 1);
      enter_reset();
      #1;
      chk("midrst_push_out", int'(push_out), 0);
      chk("midrst_word_count", int'(word_count), 0);
      chk("midrst_pop", int'(pop), 0);
      step();
      for (int k = 0; k < 4; k++) load(k, 'h3C + k);
      reset_L = 1'b1;
      @(negedge clk);
      #2;
      chk("post_rst_first_pop", int'(pop), 1);
      drain(20);

      // Randomised traffic with random pause/full.
      enter_reset();
      step();
      reset_L = 1'b1;
      for (int i = 0; i < 400; i++) begin
         step();
         if ($urandom_range(0, 2) != 0) begin
            int ch;
            ch = int'($urandom_range(0, 3));
            if (chq[ch].size() < 8) load(ch, int'($urandom_range(0, 63)));
         end
         down_pause = ($urandom_range(0, 5) == 0);
         down_full  = ($urandom_range(0, 9) == 0);
      end
      down_pause = 1'b0;
      down_full  = 1'b0;
      drain(60);
      chk("rand_word_count", int'(word_count), m_cnt);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
